// File: rtl/lin_sched_pkg.sv
// Shared types and constants for the LIN master schedule engine.
// States, reserved frame identifiers and the layout of a schedule-table entry.
package lin_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_SLOT,
        ST_SLEEP_HDR,
        ST_SLEEP_SLOT,
        ST_SLEEPING,
        ST_DIAG_MRF,
        ST_DIAG_SRF
    } sched_state_t;

    // Reserved LIN identifiers: master request (also carries go-to-sleep) and slave response
    localparam logic [5:0] PID_MRF   = 6'h3C;
    localparam logic [5:0] PID_SRF   = 6'h3D;
    localparam logic [5:0] PID_SLEEP = 6'h3C;

    // Table entry layout: {slot_ticks[SLOT_W-1:0], pid[5:0]}
    localparam int ENT_PID_LSB  = 0;
    localparam int ENT_PID_W    = 6;
    localparam int ENT_SLOT_LSB = 6;

endpackage

// File: rtl/lin_bus_idle_mon.sv
// Bus inactivity monitor: counts bit-time ticks since the last bus edge,
// saturating at INACTIVE, and raises a registered flag while saturated.
// Bus activity wins over a coincident tick and clears the count to zero.
module lin_bus_idle_mon #(
    parameter int INACTIVE = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic bus_activity,
    output logic bus_inactive
);

    localparam int CW = $clog2(INACTIVE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(INACTIVE);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_inactive;

    // Next count: clear on activity, otherwise step on tick until saturated
    always_comb begin
        w_cnt_next = r_cnt;
        if (bus_activity) begin
            w_cnt_next = '0;
        end else if (tick && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    // Counter and flag registers; the flag tracks the registered count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_inactive <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_inactive <= (w_cnt_next == CNT_MAX);
        end
    end

    assign bus_inactive = r_inactive;

endmodule

// File: rtl/lin_master_sched.sv
// LIN master schedule engine: walks a DEPTH-entry table, issuing one header
// per slot to the frame engine (valid/ready), supervises each response,
// counts frame errors, inserts go-to-sleep slots and monitors bus inactivity.
// Optional diagnostic MRF/SRF slot insertion is built when LIN_DIAG_EN is defined;
// otherwise diag_req is ignored and diag_busy is tied low.
module lin_master_sched
    import lin_sched_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH),
    parameter int SLOT_W     = 10,
    parameter int INACTIVE   = 30,
    parameter int SLEEP_SLOT = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [SLOT_W+5:0] cfg_wdata,
    input  logic [AW:0]       nb_of_frames,
    input  logic              en_schedule,
    input  logic              sleep_cmd,
    output logic              hdr_valid,
    output logic [5:0]        hdr_pid,
    output logic              hdr_sleep,
    input  logic              hdr_ready,
    input  logic              resp_done,
    input  logic              resp_error,
    input  logic              bus_activity,
    output logic              bus_inactive,
    output logic              sleeping,
    output logic [AW-1:0]     cur_index,
    output logic [7:0]        err_count,
    input  logic              diag_req,
    output logic              diag_busy
);

    localparam int NW = AW + 1;
    localparam logic [SLOT_W-1:0] SLEEP_LEN = SLOT_W'(SLEEP_SLOT);

    // Schedule table (contents survive reset) and its registered read port
    logic [SLOT_W+5:0] r_table [DEPTH];
    logic [SLOT_W+5:0] r_rd_data;

    sched_state_t      r_state;
    sched_state_t      w_state_next;
    logic [AW-1:0]     r_cur_index;
    logic [AW-1:0]     w_index_next;
    logic [5:0]        r_pid;
    logic [SLOT_W-1:0] r_slot_len;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [7:0]        r_err_count;
    logic              r_sleep_pend;
    logic              r_done_seen;
    logic              r_err_seen;
    logic              r_diag_phase;   // 0: inserted header pending, 1: inserted slot running

    logic              w_sleep_pend;
    logic              w_sleep_serve;
    logic              w_diag_req;
    logic              w_hdr_fire;
    logic              w_counting;
    logic              w_slot_end;
    logic              w_frame_err;
    logic              w_count_err;
    logic              w_run_ok;
    logic [AW:0]       w_idx_ext;
    logic [AW:0]       w_idx_inc;
    logic [AW-1:0]     w_idx_adv;
    logic [AW-1:0]     w_idx_fit;
    logic [SLOT_W-1:0] w_ent_slot;

`ifdef LIN_DIAG_EN
    assign w_diag_req = diag_req;
    assign diag_busy  = (r_state == ST_DIAG_MRF) || (r_state == ST_DIAG_SRF);
`else
    logic w_unused_diag;
    assign w_diag_req    = 1'b0;
    assign diag_busy     = 1'b0;
    assign w_unused_diag = diag_req;
`endif

    // A sleep request arriving in the deciding cycle is honoured immediately
    assign w_sleep_pend = r_sleep_pend | sleep_cmd;
    assign w_run_ok     = en_schedule && (nb_of_frames != '0);

    // Index arithmetic: advance with wrap, and clamp when the table was shortened
    assign w_idx_ext = {1'b0, r_cur_index};
    assign w_idx_inc = w_idx_ext + NW'(1);
    assign w_idx_adv = (w_idx_inc >= nb_of_frames) ? '0 : w_idx_inc[AW-1:0];
    assign w_idx_fit = (w_idx_ext >= nb_of_frames) ? '0 : r_cur_index;

    assign w_hdr_fire = hdr_valid && hdr_ready;
    assign w_counting = (r_state == ST_SLOT) || (r_state == ST_SLEEP_SLOT) ||
                        (((r_state == ST_DIAG_MRF) || (r_state == ST_DIAG_SRF)) && r_diag_phase);
    assign w_slot_end = w_counting && tick && (r_slot_cnt == SLOT_W'(1));

    // Response judgement includes pulses landing on the slot-end cycle itself
    assign w_frame_err = r_err_seen || resp_error || !(r_done_seen || resp_done);
    assign w_count_err = w_slot_end && w_frame_err &&
                         ((r_state == ST_SLOT) || (r_state == ST_DIAG_SRF));

    assign w_ent_slot = r_rd_data[ENT_SLOT_LSB +: SLOT_W];

    // Table write port, usable at any time
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_table[cfg_addr] <= cfg_wdata;
        end
    end

    // Registered read addressed by the next index, so LOAD sees its own entry
    always_ff @(posedge clk) begin
        r_rd_data <= r_table[w_index_next];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, index update and header outputs
    always_comb begin
        w_state_next  = r_state;
        w_index_next  = r_cur_index;
        w_sleep_serve = 1'b0;
        hdr_valid     = 1'b0;
        hdr_pid       = '0;
        hdr_sleep     = 1'b0;
        sleeping      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sleep_pend) begin
                    w_state_next  = ST_SLEEP_HDR;
                    w_sleep_serve = 1'b1;
                end else if (w_run_ok) begin
                    w_state_next = ST_LOAD;
                    w_index_next = w_idx_fit;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_HDR;
            end
            ST_HDR: begin
                hdr_valid = 1'b1;
                hdr_pid   = r_pid;
                if (hdr_ready) begin
                    w_state_next = ST_SLOT;
                end
            end
            ST_SLOT: begin
                if (w_slot_end) begin
                    w_index_next = w_idx_adv;
                    if (w_sleep_pend) begin
                        w_state_next  = ST_SLEEP_HDR;
                        w_sleep_serve = 1'b1;
                    end else if (w_diag_req) begin
                        w_state_next = ST_DIAG_MRF;
                    end else if (!w_run_ok) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_LOAD;
                    end
                end
            end
            ST_SLEEP_HDR: begin
                hdr_valid = 1'b1;
                hdr_pid   = PID_SLEEP;
                hdr_sleep = 1'b1;
                if (hdr_ready) begin
                    w_state_next = ST_SLEEP_SLOT;
                end
            end
            ST_SLEEP_SLOT: begin
                if (w_slot_end) begin
                    w_state_next = ST_SLEEPING;
                end
            end
            ST_SLEEPING: begin
                sleeping = 1'b1;
                if (bus_activity) begin
                    w_state_next = ST_IDLE;
                    w_index_next = '0;
                end
            end
            ST_DIAG_MRF: begin
                if (!r_diag_phase) begin
                    hdr_valid = 1'b1;
                    hdr_pid   = PID_MRF;
                end else if (w_slot_end) begin
                    w_state_next = ST_DIAG_SRF;
                end
            end
            ST_DIAG_SRF: begin
                if (!r_diag_phase) begin
                    hdr_valid = 1'b1;
                    hdr_pid   = PID_SRF;
                end else if (w_slot_end) begin
                    if (w_sleep_pend) begin
                        w_state_next  = ST_SLEEP_HDR;
                        w_sleep_serve = 1'b1;
                    end else if (!w_run_ok) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_LOAD;
                        w_index_next = w_idx_fit;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Slot datapath: entry latch, slot counter, response flags, error count, requests
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_index  <= '0;
            r_pid        <= '0;
            r_slot_len   <= '0;
            r_slot_cnt   <= '0;
            r_err_count  <= '0;
            r_sleep_pend <= 1'b0;
            r_done_seen  <= 1'b0;
            r_err_seen   <= 1'b0;
            r_diag_phase <= 1'b0;
        end else begin
            r_cur_index <= w_index_next;

            if (w_sleep_serve) begin
                r_sleep_pend <= 1'b0;
            end else if (sleep_cmd && (r_state != ST_SLEEPING)) begin
                r_sleep_pend <= 1'b1;
            end

            if (r_state == ST_LOAD) begin
                r_pid      <= r_rd_data[ENT_PID_LSB +: ENT_PID_W];
                r_slot_len <= (w_ent_slot == '0) ? SLOT_W'(1) : w_ent_slot;
            end

            if (w_hdr_fire) begin
                r_slot_cnt  <= (r_state == ST_SLEEP_HDR) ? SLEEP_LEN : r_slot_len;
                r_done_seen <= 1'b0;
                r_err_seen  <= 1'b0;
            end else if (w_counting) begin
                if (tick) begin
                    r_slot_cnt <= r_slot_cnt - SLOT_W'(1);
                end
                if (resp_done) begin
                    r_done_seen <= 1'b1;
                end
                if (resp_error) begin
                    r_err_seen <= 1'b1;
                end
            end

            if (w_count_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end

            if (w_hdr_fire && ((r_state == ST_DIAG_MRF) || (r_state == ST_DIAG_SRF))) begin
                r_diag_phase <= 1'b1;
            end else if (w_slot_end) begin
                r_diag_phase <= 1'b0;
            end
        end
    end

    lin_bus_idle_mon #(
        .INACTIVE(INACTIVE)
    ) u_idle_mon (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .bus_activity(bus_activity),
        .bus_inactive(bus_inactive)
    );

    assign cur_index = r_cur_index;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_lin_master_sched.sv
// Self-checking bench for lin_master_sched: table-driven slot vectors plus
// directed sequences for handshake hold, error saturation, sleep/wake,
// inactivity timing, reset mid-transaction and diagnostic insertion.
module tb_lin_master_sched;

    localparam int AW     = 4;
    localparam int SLOT_W = 10;

    logic              clk;
    logic              reset;
    logic              tick;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [SLOT_W+5:0] cfg_wdata;
    logic [AW:0]       nb_of_frames;
    logic              en_schedule;
    logic              sleep_cmd;
    logic              hdr_valid;
    logic [5:0]        hdr_pid;
    logic              hdr_sleep;
    logic              hdr_ready;
    logic              resp_done;
    logic              resp_error;
    logic              bus_activity;
    logic              bus_inactive;
    logic              sleeping;
    logic [AW-1:0]     cur_index;
    logic [7:0]        err_count;
    logic              diag_req;
    logic              diag_busy;

    lin_master_sched dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .nb_of_frames(nb_of_frames),
        .en_schedule (en_schedule),
        .sleep_cmd   (sleep_cmd),
        .hdr_valid   (hdr_valid),
        .hdr_pid     (hdr_pid),
        .hdr_sleep   (hdr_sleep),
        .hdr_ready   (hdr_ready),
        .resp_done   (resp_done),
        .resp_error  (resp_error),
        .bus_activity(bus_activity),
        .bus_inactive(bus_inactive),
        .sleeping    (sleeping),
        .cur_index   (cur_index),
        .err_count   (err_count),
        .diag_req    (diag_req),
        .diag_busy   (diag_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0] pid;
        int         ticks;
        logic       done;
        logic       err;
        int         err_after;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 100 && !hdr_valid; k++) step();
        if (!hdr_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: hdr_valid timeout got 0 expected 1", name);
        end
    endtask

    // Wait for a header, check it, accept it (hdr_ready must be 1)
    task automatic wait_hdr(input string name, input int exp_pid, input int exp_sleep);
        wait_valid(name);
        chk({name, "_pid"}, hdr_pid, exp_pid);
        chk({name, "_sleep"}, hdr_sleep, exp_sleep);
        $display("hdr %s pid=%02h sleep=%0d idx=%0d", name, hdr_pid, hdr_sleep, cur_index);
        step();
    endtask

    // Run one slot: optional response pulses, then ticks until the slot ends
    task automatic run_slot(input logic done, input logic err, output int nticks);
        logic [AW-1:0] start;
        start  = cur_index;
        nticks = 0;
        if (done || err) begin
            resp_done  = done;
            resp_error = err;
            step();
            resp_done  = 1'b0;
            resp_error = 1'b0;
        end
        for (int k = 1; k <= 100; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if ((cur_index != start) || sleeping || hdr_valid) begin
                nticks = k;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hdr_valid"}, hdr_valid, 0);
        chk({tag, "_hdr_pid"}, hdr_pid, 0);
        chk({tag, "_hdr_sleep"}, hdr_sleep, 0);
        chk({tag, "_sleeping"}, sleeping, 0);
        chk({tag, "_cur_index"}, cur_index, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_bus_inactive"}, bus_inactive, 0);
        chk({tag, "_diag_busy"}, diag_busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        int exp_pid;

        vecs[0] = '{6'h10, 3, 1'b1, 1'b0, 0};
        vecs[1] = '{6'h11, 5, 1'b1, 1'b0, 0};
        vecs[2] = '{6'h10, 3, 1'b1, 1'b0, 0};
        vecs[3] = '{6'h11, 5, 1'b0, 1'b0, 1};
        vecs[4] = '{6'h10, 3, 1'b1, 1'b1, 2};
        vecs[5] = '{6'h11, 5, 1'b1, 1'b0, 2};

        reset = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        nb_of_frames = '0; en_schedule = 1'b0; sleep_cmd = 1'b0; hdr_ready = 1'b0;
        resp_done = 1'b0; resp_error = 1'b0; bus_activity = 1'b0; diag_req = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        reset = 1'b0;

        // Program the two-entry schedule
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = {10'd3, 6'h10};
        step();
        cfg_addr = 4'd1; cfg_wdata = {10'd5, 6'h11};
        step();
        cfg_we = 1'b0;
        nb_of_frames = 5'd2;
        hdr_ready    = 1'b1;
        en_schedule  = 1'b1;

        // Table-driven slots: PID order, slot lengths, error counting
        for (int i = 0; i < 6; i++) begin
            wait_hdr($sformatf("v%0d", i), int'(vecs[i].pid), 0);
            run_slot(vecs[i].done, vecs[i].err, nt);
            chk($sformatf("v%0d_ticks", i), nt, vecs[i].ticks);
            chk($sformatf("v%0d_err", i), err_count, vecs[i].err_after);
            $display("slot v%0d ticks=%0d err=%0d", i, nt, err_count);
        end

        // Header held for 7+ cycles with hdr_ready low; rewrite table meanwhile
        hdr_ready = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = {10'd0, 6'h10};
        step();
        cfg_addr = 4'd1; cfg_wdata = {10'd0, 6'h11};
        step();
        cfg_we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("hold%0d_valid", i), hdr_valid, 1);
            chk($sformatf("hold%0d_pid", i), hdr_pid, 'h10);
            step();
        end
        hdr_ready = 1'b1;
        wait_hdr("post_hold", 'h10, 0);
        run_slot(1'b0, 1'b0, nt);
        chk("post_hold_ticks", nt, 3);
        chk("post_hold_err", err_count, 3);

        // 300 errored slots of length 0 (runs as 1 tick): count saturates at 255
        for (int i = 0; i < 300; i++) begin
            exp_pid = ((i % 2) == 0) ? 'h11 : 'h10;
            wait_hdr($sformatf("sat%0d", i), exp_pid, 0);
            run_slot(1'b0, 1'b0, nt);
            if (i == 0)   chk("zero_len_ticks", nt, 1);
            if (i == 250) chk("sat_err_254", err_count, 254);
            if (i == 299) chk("sat_err_255", err_count, 255);
        end

        // Sleep request mid-slot on idx0: sleep header follows, then 40-tick slot
        wait_hdr("pre1", 'h11, 0);
        run_slot(1'b1, 1'b0, nt);
        wait_hdr("pre_sleep", 'h10, 0);
        sleep_cmd = 1'b1;
        step();
        sleep_cmd = 1'b0;
        run_slot(1'b1, 1'b0, nt);
        chk("pre_sleep_idx", cur_index, 1);
        wait_hdr("sleep_hdr", 'h3C, 1);
        en_schedule = 1'b0;
        run_slot(1'b0, 1'b0, nt);
        chk("sleep_ticks", nt, 40);
        chk("sleeping_set", sleeping, 1);
        chk("sleep_no_err", err_count, 255);
        step();
        step();
        step();
        chk("sleep_no_hdr", hdr_valid, 0);
        chk("sleep_hold", sleeping, 1);
        chk("inactive_in_sleep", bus_inactive, 1);
        bus_activity = 1'b1;
        step();
        bus_activity = 1'b0;
        chk("wake_sleeping", sleeping, 0);
        chk("wake_inactive", bus_inactive, 0);
        chk("wake_idx", cur_index, 0);
        $display("wake idx=%0d sleeping=%0d", cur_index, sleeping);

        // Inactivity threshold and coincident activity/tick
        tick_n(29);
        chk("inact_29", bus_inactive, 0);
        tick_n(1);
        chk("inact_30", bus_inactive, 1);
        bus_activity = 1'b1;
        step();
        bus_activity = 1'b0;
        chk("inact_clear", bus_inactive, 0);
        tick_n(29);
        tick = 1'b1; bus_activity = 1'b1;
        step();
        tick = 1'b0; bus_activity = 1'b0;
        tick_n(29);
        chk("coinc_29", bus_inactive, 0);
        tick_n(1);
        chk("coinc_30", bus_inactive, 1);

        // Reset mid-handshake with a pending sleep request
        hdr_ready   = 1'b0;
        en_schedule = 1'b1;
        wait_valid("rst_hs");
        chk("rst_hs_pid", hdr_pid, 'h10);
        sleep_cmd = 1'b1;
        step();
        sleep_cmd = 1'b0;
        reset = 1'b1;
        step();
        chk_all_zero("rst_hs");
        reset     = 1'b0;
        hdr_ready = 1'b1;
        wait_hdr("after_rst", 'h10, 0);
        run_slot(1'b0, 1'b0, nt);
        chk("after_rst_err", err_count, 1);
        chk("after_rst_idx", cur_index, 1);

        // Reset mid-slot
        wait_hdr("mid_slot", 'h11, 0);
        reset = 1'b1;
        step();
        chk_all_zero("rst_slot");
        en_schedule  = 1'b0;
        reset        = 1'b0;

        // Empty schedule keeps the engine idle
        nb_of_frames = '0;
        en_schedule  = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("nb0_no_hdr", hdr_valid, 0);
        nb_of_frames = 5'd2;

        // Diagnostic request at the slot end of idx1
        wait_hdr("d_pre0", 'h10, 0);
        run_slot(1'b1, 1'b0, nt);
        wait_hdr("d_pre1", 'h11, 0);
        diag_req = 1'b1;
        run_slot(1'b1, 1'b0, nt);
        diag_req = 1'b0;
`ifdef LIN_DIAG_EN
        chk("diag_busy_mrf", diag_busy, 1);
        wait_hdr("d_mrf", 'h3C, 0);
        run_slot(1'b1, 1'b0, nt);
        chk("diag_busy_srf", diag_busy, 1);
        wait_hdr("d_srf", 'h3D, 0);
        run_slot(1'b1, 1'b0, nt);
        chk("diag_busy_end", diag_busy, 0);
        wait_hdr("d_resume", 'h10, 0);
`else
        chk("diag_busy_off", diag_busy, 0);
        wait_hdr("d_resume", 'h10, 0);
        chk("diag_busy_off2", diag_busy, 0);
`endif
        en_schedule = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
